// File: rtl/minex_pkg.sv
// Shared definitions for the min-plus / min-times reduction controller.
//   state_t     : controller FSM states (IDLE, RUN, OUT)
//   FUNC_PLUS   : pair operation is a1+a2
//   FUNC_TIMES  : pair operation is a1*a2
//   MINEX_IDENT : min identity (all-ones) at the default width; width-generic
//                 users fill with '1 at their own W.
package minex_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic FUNC_PLUS  = 1'b0;
  localparam logic FUNC_TIMES = 1'b1;

  localparam int unsigned         MINEX_W     = 16;
  localparam logic [MINEX_W-1:0]  MINEX_IDENT = '1;

endpackage

// File: rtl/minex_core.sv
// Combinational 4-pair reduction: forms four pair values from one beat and
// returns the unsigned minimum of those values and the running accumulator.
//   i_func : FUNC_PLUS (sum) or FUNC_TIMES (product)
//   i_data : packed {a1,a2,b1,b2,c1,c2,d1,d2}, a1 in the MSBs
//   i_acc  : current accumulator
//   o_min  : min(pairA, pairB, pairC, pairD, i_acc)
// Macro MINEX_SAT_EN: when defined, pair results above 2^W-1 clamp to
// all-ones; otherwise they wrap modulo 2^W.
module minex_core
  import minex_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic           i_func,
  input  logic [8*W-1:0] i_data,
  input  logic [W-1:0]   i_acc,
  output logic [W-1:0]   o_min
);

  function automatic logic [W-1:0] pair_op(input logic f,
                                           input logic [W-1:0] x,
                                           input logic [W-1:0] y);
`ifdef MINEX_SAT_EN
    logic [2*W-1:0] wide;
    if (f == FUNC_TIMES)
      wide = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    else
      wide = {{W{1'b0}}, x} + {{W{1'b0}}, y};
    if (|wide[2*W-1:W])
      return '1;
    else
      return wide[W-1:0];
`else
    if (f == FUNC_TIMES)
      return x * y;
    else
      return x + y;
`endif
  endfunction

  logic [W-1:0] w_pair;
  logic [W-1:0] w_min;

  always_comb begin
    w_pair = '0;
    w_min  = i_acc;
    for (int unsigned p = 0; p < 4; p++) begin
      w_pair = pair_op(i_func, i_data[(7-2*p)*W +: W], i_data[(6-2*p)*W +: W]);
      if (w_pair < w_min)
        w_min = w_pair;
    end
  end

  assign o_min = w_min;

endmodule

// File: rtl/minex_reduce_ctrl.sv
// Reduction job controller: accepts k_chunks beats of four operand pairs and
// returns the minimum pair value (sum or product) over the whole job.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start, func,
//   k_chunks        : job request (func/k_chunks sampled on accepted start)
//   busy            : high outside IDLE
//   in_valid/ready,
//   in_data         : operand beat stream {a1,a2,b1,b2,c1,c2,d1,d2}
//   out_valid/ready,
//   out_data        : result handshake
//   done            : pulse in the cycle the result handshake completes
// Macro MINEX_SAT_EN (applied in minex_core) selects saturating pair arithmetic.
module minex_reduce_ctrl
  import minex_pkg::*;
#(
  parameter int unsigned W  = 16,
  parameter int unsigned CW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           func,
  input  logic [CW-1:0]  k_chunks,
  output logic           busy,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [8*W-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic           done
);

  state_t        r_state;
  state_t        w_state_next;
  logic          r_func;
  logic [CW-1:0] r_k;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_acc;

  logic          w_start_acc;
  logic          w_beat;
  logic [CW-1:0] w_cnt_inc;
  logic [W-1:0]  w_min;

  assign w_start_acc = (r_state == IDLE) && start;
  assign w_beat      = (r_state == RUN) && in_valid;
  assign w_cnt_inc   = r_cnt + CW'(1);

  minex_core #(
    .W (W)
  ) u_core (
    .i_func (r_func),
    .i_data (in_data),
    .i_acc  (r_acc),
    .o_min  (w_min)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start)
          w_state_next = (k_chunks == '0) ? OUT : RUN;
      end
      RUN: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (in_valid && (w_cnt_inc == r_k))
          w_state_next = OUT;
      end
      OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          done         = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_func <= FUNC_PLUS;
      r_k    <= '0;
      r_cnt  <= '0;
      r_acc  <= '1;
    end else if (w_start_acc) begin
      r_func <= func;
      r_k    <= k_chunks;
      r_cnt  <= '0;
      r_acc  <= '1;
    end else if (w_beat) begin
      r_cnt  <= w_cnt_inc;
      r_acc  <= w_min;
    end
  end

  assign out_data = r_acc;

endmodule

// File: tb/tb_minex_reduce_ctrl.sv
module tb_minex_reduce_ctrl;

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           func;
  logic [CW-1:0]  k_chunks;
  logic           busy;
  logic           in_valid;
  logic           in_ready;
  logic [8*W-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic           done;

  minex_reduce_ctrl #(.W(W), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .func      (func),
    .k_chunks  (k_chunks),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .done      (done)
  );

  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  logic [W-1:0] sb[$];

  typedef struct {
    logic           f;
    int unsigned    k;
    logic [8*W-1:0] b0;
    logic [8*W-1:0] b1;
    logic [8*W-1:0] b2;
    logic [W-1:0]   exp;
  } vec_t;

  vec_t vecs[6];

  task automatic checkw(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h, expected 0x%h at %0t", nm, act, exp, $time);
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [8*W-1:0] pk(input int unsigned a1, a2, b1, b2, c1, c2, d1, d2);
    return {W'(a1), W'(a2), W'(b1), W'(b2), W'(c1), W'(c2), W'(d1), W'(d2)};
  endfunction

  // Reference pair value straight from the arithmetic definition.
  function automatic logic [W-1:0] ref_pair(input logic f, input logic [W-1:0] x, input logic [W-1:0] y);
    longint unsigned v;
    v = (f == 1'b1) ? longint'(x) * longint'(y) : longint'(x) + longint'(y);
`ifdef MINEX_SAT_EN
    if (v > 64'hFFFF) v = 64'hFFFF;
`endif
    return W'(v & 64'hFFFF);
  endfunction

  function automatic logic [W-1:0] ref_beat(input logic f, input logic [8*W-1:0] b, input logic [W-1:0] acc);
    logic [W-1:0] m, v;
    m = acc;
    for (int p = 0; p < 4; p++) begin
      v = ref_pair(f, b[(7-2*p)*W +: W], b[(6-2*p)*W +: W]);
      if (v < m) m = v;
    end
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input string nm, input logic f, input int unsigned k,
                         input logic [8*W-1:0] b0, input logic [8*W-1:0] b1,
                         input logic [8*W-1:0] b2, input logic [W-1:0] exp,
                         input int unsigned gap, input int unsigned hold,
                         input bit start_in_out, input bit start_at_hs);
    logic [W-1:0] e;
    logic [8*W-1:0] bt;
    start = 1'b1; func = f; k_chunks = CW'(k);
    tick();
    start = 1'b0; func = ~f; k_chunks = CW'(0);
    sb.push_back(exp);
    check1({nm, " busy after start"}, busy, 1'b1);
    if (k == 0) begin
      check1({nm, " k0 out_valid next cycle"}, out_valid, 1'b1);
      check1({nm, " k0 in_ready"}, in_ready, 1'b0);
    end
    for (int i = 0; i < int'(k); i++) begin
      for (int g = 0; g < int'(gap); g++) begin
        in_valid = 1'b0;
        in_data  = '1;
        tick();
        check1({nm, " gap in_ready"}, in_ready, 1'b1);
        check1({nm, " gap out_valid"}, out_valid, 1'b0);
      end
      bt = (i == 0) ? b0 : (i == 1) ? b1 : b2;
      in_valid = 1'b1;
      in_data  = bt;
      check1({nm, " in_ready in RUN"}, in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      in_data  = '0;
      check1({nm, " out_valid after beat"}, out_valid, (i == int'(k) - 1));
    end
    if (sb.size() == 0) begin
      $display("FAIL %s: scoreboard empty", nm);
      n_total++;
      e = '0;
    end else begin
      e = sb.pop_front();
    end
    for (int h = 0; h < int'(hold); h++) begin
      start = (start_in_out && h == 1);
      checkw({nm, " out_data held"}, out_data, e);
      check1({nm, " out_valid held"}, out_valid, 1'b1);
      check1({nm, " no done while held"}, done, 1'b0);
      tick();
    end
    start = 1'b0;
    check1({nm, " still busy before handshake"}, busy, 1'b1);
    out_ready = 1'b1;
    start = start_at_hs;
    #1;
    checkw({nm, " out_data"}, out_data, e);
    check1({nm, " done at handshake"}, done, 1'b1);
    tick();
    out_ready = 1'b0;
    start = 1'b0;
    check1({nm, " idle after handshake"}, busy, 1'b0);
    check1({nm, " single done"}, done, 1'b0);
    check1({nm, " out_valid dropped"}, out_valid, 1'b0);
  endtask

  initial begin
    logic [W-1:0] m;
    logic [8*W-1:0] rb[3];
    logic rf;
    int unsigned rk;

    rst = 1'b1; start = 1'b0; func = 1'b0; k_chunks = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    vecs[0] = '{1'b0, 1, pk(1,2,3,4,0,1,5,5), '0, '0, 16'h0001};
    vecs[1] = '{1'b1, 2, pk(2,3,4,4,9,1,7,7), pk(1,5,2,2,3,3,8,1), '0, 16'h0004};
    vecs[2] = '{1'b0, 0, '0, '0, '0, 16'hFFFF};
`ifdef MINEX_SAT_EN
    vecs[3] = '{1'b0, 1, pk(16'hFFFF,2,16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF), '0, '0, 16'hFFFF};
    vecs[4] = '{1'b1, 1, pk(16'h100,16'h100,3,5,16'hFFFF,1,2,8), '0, '0, 16'd15};
`else
    vecs[3] = '{1'b0, 1, pk(16'hFFFF,2,16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF), '0, '0, 16'h0001};
    vecs[4] = '{1'b1, 1, pk(16'h100,16'h100,3,5,16'hFFFF,1,2,8), '0, '0, 16'h0000};
`endif
    vecs[5] = '{1'b0, 3, pk(10,10,20,20,30,30,40,40), pk(9,9,50,1,100,0,7,8), pk(1,1,2,2,3,3,4,4), 16'd2};

    #3;
    check1("reset busy", busy, 1'b0);
    check1("reset in_ready", in_ready, 1'b0);
    check1("reset out_valid", out_valid, 1'b0);
    check1("reset done", done, 1'b0);
    checkw("reset out_data", out_data, 16'hFFFF);
    tick(); tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++)
      run_job($sformatf("vec%0d", i), vecs[i].f, vecs[i].k, vecs[i].b0, vecs[i].b1,
              vecs[i].b2, vecs[i].exp, 0, 0, 1'b0, 1'b0);

    // Gapped input, delayed consumer, start ignored during OUT and at handshake.
    run_job("gapped", vecs[5].f, vecs[5].k, vecs[5].b0, vecs[5].b1, vecs[5].b2,
            vecs[5].exp, 2, 5, 1'b1, 1'b1);

    // Mid-job reset abort.
    start = 1'b1; func = 1'b1; k_chunks = CW'(3);
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = pk(1,1,1,1,1,1,1,1);
    tick();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check1("abort busy", busy, 1'b0);
    check1("abort done", done, 1'b0);
    check1("abort out_valid", out_valid, 1'b0);
    checkw("abort out_data", out_data, 16'hFFFF);
    tick();
    rst = 1'b0;
    tick();
    check1("abort stays idle", busy, 1'b0);
    run_job("fresh", 1'b0, 1, pk(8,9,20,1,6,6,100,100), '0, '0, 16'd12, 0, 1, 1'b0, 1'b0);

    // Random jobs against the reference model.
    for (int j = 0; j < 8; j++) begin
      rf = 1'($urandom_range(0, 1));
      rk = $urandom_range(1, 3);
      m = '1;
      for (int b = 0; b < 3; b++) begin
        for (int p = 0; p < 8; p++)
          rb[b][p*W +: W] = (j % 2 == 0) ? W'($urandom_range(0, 300)) : W'($urandom);
        if (b < int'(rk)) m = ref_beat(rf, rb[b], m);
      end
      run_job($sformatf("rand%0d", j), rf, rk, rb[0], rb[1], rb[2], m,
              j % 3, j % 4, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/minex_reduce_ctrl.md
MINEX_REDUCE_CTRL -- requirements
Module: minex_reduce_ctrl

Interface
REQ-001 Parameter W, default 16, operand and result width in bits.
REQ-002 Parameter CW, default 8, width of the chunk-count field.
REQ-003 clk  input  1  single clock; all state is updated on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  begin a reduction job; accepted only in IDLE.
REQ-006 func  input  1  0 = min-plus (pair sum), 1 = min-times (pair product); sampled at accepted start.
REQ-007 k_chunks  input  CW  number of 4-pair beats in the job; sampled at accepted start.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 in_valid  input  1  an operand beat is present.
REQ-010 in_ready  output  1  the block accepts a beat this cycle.
REQ-011 in_data  input  8*W  packed {a1,a2,b1,b2,c1,c2,d1,d2}, with a1 in the MSBs.
REQ-012 out_valid  output  1  result is valid.
REQ-013 out_ready  input  1  the consumer accepts the result.
REQ-014 out_data  output  W  reduced minimum.
REQ-015 done  output  1  single-cycle pulse in the cycle the result handshake completes.

Function
REQ-016 The FSM shall have three states: IDLE, RUN and OUT.
REQ-017 IDLE->RUN on start=1 when k_chunks>0; IDLE->OUT on start=1 when k_chunks=0.
REQ-018 On an accepted start, the block shall latch func and k_chunks, clear the beat counter and load the accumulator with all-ones (the min identity).
REQ-019 in_ready shall equal 1 only in RUN; a beat is accepted when in_valid and in_ready are both 1.
REQ-020 On each accepted beat: pair value = a1+a2 (func=0) or a1*a2 (func=1), truncated to W bits; likewise for pairs b, c and d.
REQ-021 On each accepted beat: acc <= min(pairA, pairB, pairC, pairD, acc), using unsigned comparison.
REQ-022 The beat counter shall increment on each accepted beat; RUN->OUT on the beat that makes the count equal the latched k_chunks.
REQ-023 out_valid shall be 1 throughout OUT, and out_data shall equal acc, held stable until out_ready=1.
REQ-024 Latency: out_valid rises in the cycle after the final beat is accepted, or the cycle after start when k_chunks=0.
REQ-025 OUT->IDLE when out_ready=1, with done=1 in that same cycle.
REQ-026 A start arriving while busy=1 shall be ignored without side effects.
REQ-027 A start in the same cycle as an OUT->IDLE transition shall be ignored; it is accepted only when sampled in IDLE.
REQ-028 in_valid=0 in RUN shall stall the block, with no change to the counter or the accumulator.
REQ-029 Ties between equal values may select any input; the resulting value is identical.

Reset
REQ-030 While rst=1, state=IDLE, acc=all-ones, counter=0, latched func=0, latched k_chunks=0.
REQ-031 While rst=1, busy, in_ready, out_valid and done shall be 0, and out_data shall be all-ones.
REQ-032 Assertion of rst mid-job shall abort the job immediately, with no done pulse and no out_valid.

Configuration
REQ-033 Macro MINEX_SAT_EN controls saturating pair arithmetic.
REQ-034 With MINEX_SAT_EN defined, a pair sum or product that exceeds 2^W-1 shall clamp to all-ones.
REQ-035 Without MINEX_SAT_EN, pair sums and products shall wrap modulo 2^W.

Structure
REQ-036 A shared package minex_pkg shall hold the state enum (IDLE/RUN/OUT), the func encodings (FUNC_PLUS=0, FUNC_TIMES=1) and the identity constant (all-ones, W bits).
REQ-037 The purely combinational 4-pair-plus-accumulator reduction shall be a sub-module, minex_core, instantiated once.
REQ-038 The macro MINEX_SAT_EN shall be applied inside minex_core.

Verification (W=16)
REQ-039 func=0, k=1, beat {1,2, 3,4, 0,1, 5,5} -> out_data=1, out_valid in the cycle after the beat, done when out_ready=1.
REQ-040 func=1, k=2, beats {2,3, 4,4, 9,1, 7,7} then {1,5, 2,2, 3,3, 8,1} -> out_data=4.
REQ-041 k=0 -> OUT in the cycle after start, out_data=0xFFFF, in_ready never asserted.
REQ-042 func=0, beat {0xFFFF,2, ...rest 0xFFFF pairs} -> out_data=0x0001 without MINEX_SAT_EN, 0xFFFF with it.
REQ-043 k=3 with in_valid gapped and out_ready held low for 5 cycles -> result unchanged over the gaps, out_data stable, a start pulse during OUT ignored, single done pulse.
REQ-044 rst asserted after 1 of 3 beats -> busy=0 asynchronously, no done; a subsequent k=1 job returns the correct fresh minimum.
